// File: rtl/div_ctrl_if.sv
// rtl/div_ctrl_if.sv - pipeline-side request/result bus of the divide controller

interface div_ctrl_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        dz;
  logic [31:0] hi;
  logic [31:0] lo;

  // Pipeline side: issues requests and HI/LO writes, observes results
  modport master (
    output start, a, b, hi_we, lo_we, wdata,
    input  busy, done, dz, hi, lo
  );

  // Controller side
  modport slave (
    input  start, a, b, hi_we, lo_we, wdata,
    output busy, done, dz, hi, lo
  );
endinterface

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - issue/writeback controller for a free-running framed signed divider

module div_ctrl #(
  parameter int FRAME = 64,
  parameter int PW    = 6
) (
  input  logic        clk,
  input  logic        rst,
  div_ctrl_if.slave   bus,
  output logic [63:0] div_dnd,
  output logic [31:0] div_der,
  input  logic [31:0] div_quo,
  input  logic [31:0] div_rem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RUN,
    S_CAPT,
    S_DZ
  } state_t;

  // The phase counter mirrors the divider's own frame count. It comes up at 0
  // from device configuration and is deliberately left out of rst so that a
  // reset never knocks the controller out of step with the divider.
  logic [PW-1:0] r_phase;
  logic          w_phase_zero;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_done;
  logic          r_dz;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [63:0]   r_dnd;
  logic [31:0]   r_der;

  logic          w_done_nxt;
  logic          w_dz_nxt;
  logic [31:0]   w_hi_nxt;
  logic [31:0]   w_lo_nxt;
  logic [63:0]   w_dnd_nxt;
  logic [31:0]   w_der_nxt;

  assign w_phase_zero = (r_phase == '0);

  // Free-running frame phase, wraps FRAME-1 -> 0
  always_ff @(posedge clk) begin
    if (r_phase == PW'(FRAME - 1)) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + 1'b1;
    end
  end

  // State and output registers; rst aborts any in-flight operation silently
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dnd   <= '0;
      r_der   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_dz    <= w_dz_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_dnd   <= w_dnd_nxt;
      r_der   <= w_der_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_dz_nxt    = r_dz;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_dnd_nxt   = r_dnd;
    w_der_nxt   = r_der;

    unique case (r_state)
      S_IDLE: begin
        // Direct writes land alongside an accepted start; the division
        // result will overwrite them later.
        if (bus.hi_we) begin
          w_hi_nxt = bus.wdata;
        end
        if (bus.lo_we) begin
          w_lo_nxt = bus.wdata;
        end
        if (bus.start) begin
          w_dz_nxt = (bus.b == 32'd0);
          if (bus.b == 32'd0) begin
            // Divider operands are left alone on a divide-by-zero.
            w_state_nxt = S_DZ;
          end else begin
            w_dnd_nxt   = {{32{bus.a[31]}}, bus.a};
            w_der_nxt   = bus.b;
            w_state_nxt = S_WAIT;
          end
        end
      end

      // Operands are registered; the divider picks them up at the next
      // frame boundary, which may be a full frame away if we accepted on one.
      S_WAIT: begin
        if (w_phase_zero) begin
          w_state_nxt = S_RUN;
        end
      end

      // The result for our operands appears at the following boundary.
      S_RUN: begin
        if (w_phase_zero) begin
          w_state_nxt = S_CAPT;
        end
      end

      S_CAPT: begin
        w_lo_nxt    = div_quo;
        w_hi_nxt    = div_rem;
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end

      S_DZ: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;
  assign bus.dz   = r_dz;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
  assign div_dnd  = r_dnd;
  assign div_der  = r_der;

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - self-checking bench for div_ctrl with framed divider stand-in

module tb_div_ctrl;

  logic        clk;
  logic        rst;
  logic [63:0] div_dnd;
  logic [31:0] div_der;
  logic [31:0] div_quo;
  logic [31:0] div_rem;

  div_ctrl_if bus ();

  div_ctrl #(.FRAME(64), .PW(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .div_dnd (div_dnd),
    .div_der (div_der),
    .div_quo (div_quo),
    .div_rem (div_rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int t_acc = 0;
  logic chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sign/magnitude reference for truncating signed division, returns {rem, quo}
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] ma, mb, mq, mr;
    logic [31:0] q, r;
    ma = a[31] ? (33'd0 - {1'b1, a}) : {1'b0, a};
    mb = b[31] ? (33'd0 - {1'b1, b}) : {1'b0, b};
    mq = ma / mb;
    mr = ma % mb;
    q  = (a[31] ^ b[31]) ? 32'(33'd0 - mq) : mq[31:0];
    r  = a[31] ? 32'(33'd0 - mr) : mr[31:0];
    return {r, q};
  endfunction

  // Stand-in for the external free-running divider: loads at frame boundaries,
  // presents the result one frame later.
  logic [5:0]  m_phase;
  logic [63:0] ld_dnd;
  logic [31:0] ld_der;
  initial begin
    m_phase = '0;
    ld_dnd  = '0;
    ld_der  = '0;
    div_quo = '0;
    div_rem = '0;
  end
  always @(posedge clk) begin
    longint n, dd, q, r;
    if (m_phase == 6'd0) begin
      n  = $signed(ld_dnd);
      dd = $signed({{32{ld_der[31]}}, ld_der});
      if (dd == 0) begin
        q = 0;
        r = 0;
      end else begin
        q = n / dd;
        r = n % dd;
      end
      div_quo <= q[31:0];
      div_rem <= r[31:0];
      ld_dnd  <= div_dnd;
      ld_der  <= div_der;
    end
    m_phase <= m_phase + 6'd1;
  end

  // Behavioural model of the controller: a countdown to done per accepted request
  logic        e_busy = 1'b0, e_done = 1'b0, e_dz = 1'b0, e_isdz = 1'b0;
  logic [31:0] e_hi = '0, e_lo = '0, e_der = '0;
  logic [63:0] e_dnd = '0, e_pend = '0;
  int          e_cnt = 0;

  always @(posedge clk) begin
    int d;
    if (rst) begin
      e_busy = 1'b0; e_done = 1'b0; e_dz = 1'b0;
      e_hi = '0; e_lo = '0; e_dnd = '0; e_der = '0; e_cnt = 0;
    end else begin
      e_done = 1'b0;
      if (e_busy) begin
        e_cnt--;
        if (e_cnt == 0) begin
          e_busy = 1'b0;
          e_done = 1'b1;
          if (!e_isdz) {e_hi, e_lo} = e_pend;
        end
      end else begin
        if (bus.hi_we) e_hi = bus.wdata;
        if (bus.lo_we) e_lo = bus.wdata;
        if (bus.start) begin
          e_busy = 1'b1;
          e_dz   = (bus.b == 0);
          e_isdz = (bus.b == 0);
          if (bus.b == 0) begin
            e_cnt = 1;
          end else begin
            d      = (m_phase == 0) ? 64 : 64 - int'(m_phase);
            e_cnt  = d + 65;
            e_pend = ref_div(bus.a, bus.b);
            e_dnd  = {{32{bus.a[31]}}, bus.a};
            e_der  = bus.b;
          end
        end
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(bus.busy), 64'(e_busy));
      chk("done", 64'(bus.done), 64'(e_done));
      chk("dz",   64'(bus.dz),   64'(e_dz));
      chk("hi",   64'(bus.hi),   64'(e_hi));
      chk("lo",   64'(bus.lo),   64'(e_lo));
      chk("div_dnd", div_dnd, e_dnd);
      chk("div_der", 64'(div_der), 64'(e_der));
    end
  end

  // Called at a negedge; ph<0 means any phase
  task automatic accept(input logic [31:0] a, input logic [31:0] b, input int ph);
    int g = 0;
    while ((bus.busy || (ph >= 0 && int'(m_phase) != ph)) && g < 400) begin
      @(negedge clk);
      g++;
    end
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    t_acc = cyc;
  endtask

  task automatic wait_done(output int lat);
    int lim = 0;
    while (!bus.done && lim < 300) begin
      @(negedge clk);
      lim++;
    end
    if (!bus.done) chk("done_timeout", 64'(0), 64'(1));
    lat = cyc - t_acc;
  endtask

  task automatic op(input string nm, input logic [31:0] a, input logic [31:0] b, input int ph,
                    input int exp_lat, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int lat;
    accept(a, b, ph);
    wait_done(lat);
    if (exp_lat > 0) chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    chk({nm, "_hi"}, 64'(bus.hi), 64'(exp_hi));
  endtask

  initial begin
    int lat, ndone;
    logic [31:0] r;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_dz",   64'(bus.dz),   64'(0));
    chk("rst_hi",   64'(bus.hi),   64'(0));
    chk("rst_lo",   64'(bus.lo),   64'(0));
    chk("rst_dnd",  div_dnd,       64'(0));

    // Pinned literal cases
    op("p63",  32'd100, 32'd7, 63, 66, 32'd14, 32'd2);
    chk("p63_dz", 64'(bus.dz), 64'(0));
    op("p0",   32'hFFFF_FF9C, 32'd7, 0, 129, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    op("ovf",  32'h8000_0000, 32'hFFFF_FFFF, -1, 0, 32'h8000_0000, 32'd0);
    op("neg",  32'd7, 32'hFFFF_FFFE, -1, 0, 32'hFFFF_FFFD, 32'd1);

    // Divide by zero keeps preloaded HI/LO
    bus.hi_we = 1'b1; bus.wdata = 32'h1234;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h5678;
    @(negedge clk);
    bus.lo_we = 1'b0;
    op("dz", 32'd5, 32'd0, -1, 1, 32'h5678, 32'h1234);
    chk("dz_flag", 64'(bus.dz), 64'(1));
    op("dzclr", 32'd9, 32'd3, -1, 0, 32'd3, 32'd0);
    chk("dzclr_flag", 64'(bus.dz), 64'(0));

    // Requests and writes while busy are dropped
    accept(32'd100, 32'd7, 63);
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd3; bus.hi_we = 1'b1; bus.wdata = 32'hFFFF;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0;
    wait_done(lat);
    chk("busy_lat", 64'(lat), 64'(66));
    chk("busy_lo", 64'(bus.lo), 64'(14));
    chk("busy_hi", 64'(bus.hi), 64'(2));

    // Reset during RUN aborts without done
    accept(32'd77, 32'd5, 63);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_hi",   64'(bus.hi),   64'(0));
    chk("abort_lo",   64'(bus.lo),   64'(0));
    chk("abort_der",  64'(div_der),  64'(0));
    ndone = 0;
    repeat (140) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'(0));
    op("after_rst", 32'd50, 32'd5, -1, 0, 32'd10, 32'd0);

    // Randomized traffic checked by the model each cycle
    for (int i = 0; i < 4000; i++) begin
      r = $urandom;
      bus.start = ($urandom_range(0, 5) == 0);
      case (r[2:0])
        3'd0:    bus.a = 32'h8000_0000;
        3'd1:    bus.a = $urandom_range(0, 200);
        default: bus.a = $urandom;
      endcase
      case (r[6:4])
        3'd0:    bus.b = 32'd0;
        3'd1:    bus.b = 32'hFFFF_FFFF;
        3'd2:    bus.b = 32'($signed(-$urandom_range(1, 20)));
        3'd3:    bus.b = $urandom_range(1, 20);
        default: bus.b = $urandom;
      endcase
      bus.hi_we = ($urandom_range(0, 11) == 0);
      bus.lo_we = ($urandom_range(0, 11) == 0);
      bus.wdata = $urandom;
      rst       = ($urandom_range(0, 699) == 0);
      @(negedge clk);
    end
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; rst = 1'b0;
    repeat (140) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
